// File: rtl/ipsmacge_rxsfd.sv
// RX preamble/SFD stripper: finds the SFD, removes preamble, and delimits each
// frame with sop/eop, carrying an accumulated error flag and byte length.
module ipsmacge_rxsfd #(
  parameter int MAXLEN = 1518,
  parameter int LENW   = 14
) (
  input  logic            rxclk,
  input  logic            rxrst,
  input  logic [7:0]      rx_idat,
  input  logic            rx_idv,
  input  logic            rx_ier,
  input  logic            rx_ival,
  input  logic            upen,
  input  logic            upprechk,
  input  logic [2:0]      uppremin,
  output logic [7:0]      rx_odat,
  output logic            rx_oval,
  output logic            rx_osop,
  output logic            rx_oeop,
  output logic            rx_oerr,
  output logic [LENW-1:0] rx_olen,
  output logic            sfd_prerr,
  output logic            sfd_longerr,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;

  state_t          state, state_nx;
  logic [2:0]      precnt;
  logic [7:0]      hold;
  logic            hvld, hsop, erracc;
  logic [LENW-1:0] len;

  logic            is_pre, is_sfd, sfd_ok_idle, sfd_ok_pre, trunc;
  logic            emit, emit_eop, emit_err, prerr_nx, longerr_nx;
  logic [LENW-1:0] emit_len;

  // Valid/ready contract: there is no backpressure; every input is qualified
  // by rx_ival and every output byte/flag set is qualified by the rx_oval strobe.
  assign is_pre      = (rx_idat == 8'h55);
  assign is_sfd      = (rx_idat == 8'hD5);
  assign sfd_ok_idle = !upprechk || (uppremin == 3'd0);
  assign sfd_ok_pre  = !upprechk || (precnt >= uppremin);
  assign trunc       = hvld && (len == LENW'(MAXLEN));
  assign fsm_state   = state;

  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rx_ival) begin
      case (state)
        IDLE: if (upen && rx_idv) begin
          if (is_pre)                     state_nx = PRE;
          else if (is_sfd && sfd_ok_idle) state_nx = DATA;
          else                            state_nx = DROP;
        end
        PRE: begin
          if (!rx_idv)                   state_nx = IDLE;
          else if (is_pre)               state_nx = PRE;
          else if (is_sfd && sfd_ok_pre) state_nx = DATA;
          else                           state_nx = DROP;
        end
        DATA: begin
          if (!rx_idv)    state_nx = IDLE;
          else if (trunc) state_nx = DROP;
        end
        DROP: if (!rx_idv) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_err   = 1'b0;
    emit_len   = '0;
    prerr_nx   = 1'b0;
    longerr_nx = 1'b0;
    if (rx_ival) begin
      case (state)
        IDLE: prerr_nx = upen && rx_idv && !is_pre && !(is_sfd && sfd_ok_idle);
        PRE:  prerr_nx = !rx_idv || (!is_pre && !(is_sfd && sfd_ok_pre));
        DATA: begin
          if (rx_idv) begin
            emit = hvld;
            // Frame already at the length limit: close it out as errored.
            if (trunc) begin
              emit_eop   = 1'b1;
              emit_err   = 1'b1;
              emit_len   = len;
              longerr_nx = 1'b1;
            end
          end else if (hvld) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = erracc;
            emit_len = len;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) begin
      rx_odat     <= '0;
      rx_oval     <= 1'b0;
      rx_osop     <= 1'b0;
      rx_oeop     <= 1'b0;
      rx_oerr     <= 1'b0;
      rx_olen     <= '0;
      sfd_prerr   <= 1'b0;
      sfd_longerr <= 1'b0;
    end else begin
      rx_odat     <= emit ? hold : 8'h00;
      rx_oval     <= emit;
      rx_osop     <= emit && hsop;
      rx_oeop     <= emit_eop;
      rx_oerr     <= emit_err;
      rx_olen     <= emit_len;
      sfd_prerr   <= prerr_nx;
      sfd_longerr <= longerr_nx;
    end
  end

  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) begin
      precnt <= '0;
      hold   <= '0;
      hvld   <= 1'b0;
      hsop   <= 1'b0;
      erracc <= 1'b0;
      len    <= '0;
    end else if (rx_ival) begin
      if (state == IDLE && upen && rx_idv && is_pre) precnt <= 3'd1;
      if (state == PRE && rx_idv && is_pre && precnt != 3'd7) precnt <= precnt + 3'd1;
      if (state != DATA && state_nx == DATA) begin
        hvld   <= 1'b0;
        hsop   <= 1'b0;
        erracc <= 1'b0;
        len    <= '0;
      end
      if (state == DATA) begin
        if (rx_idv && !trunc) begin
          // Only the first byte after the SFD loads while the register is empty.
          hold   <= rx_idat;
          hsop   <= !hvld;
          hvld   <= 1'b1;
          len    <= len + LENW'(1);
          erracc <= erracc | rx_ier;
        end else begin
          hvld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipsmacge_rxsfd.sv
// Directed bench for ipsmacge_rxsfd: driver tasks push expected output bytes
// into a queue; a negedge monitor pops and compares every rx_oval strobe.
module tb_ipsmacge_rxsfd;

  localparam int MAXLEN = 100;
  localparam int LENW   = 14;
  localparam int EW     = 8 + 3 + LENW;

  logic            rxclk = 1'b0;
  logic            rxrst;
  logic [7:0]      rx_idat;
  logic            rx_idv, rx_ier, rx_ival;
  logic            upen, upprechk;
  logic [2:0]      uppremin;
  logic [7:0]      rx_odat;
  logic            rx_oval, rx_osop, rx_oeop, rx_oerr;
  logic [LENW-1:0] rx_olen;
  logic            sfd_prerr, sfd_longerr;
  logic [1:0]      fsm_state;

  int checks = 0;
  int errors = 0;
  int prerr_seen = 0, longerr_seen = 0;
  int exp_prerr = 0, exp_longerr = 0;
  logic ival_q = 1'b0;
  logic [EW-1:0] exp_q[$];

  ipsmacge_rxsfd #(.MAXLEN(MAXLEN), .LENW(LENW)) dut (
    .rxclk(rxclk), .rxrst(rxrst), .rx_idat(rx_idat), .rx_idv(rx_idv),
    .rx_ier(rx_ier), .rx_ival(rx_ival), .upen(upen), .upprechk(upprechk),
    .uppremin(uppremin), .rx_odat(rx_odat), .rx_oval(rx_oval),
    .rx_osop(rx_osop), .rx_oeop(rx_oeop), .rx_oerr(rx_oerr),
    .rx_olen(rx_olen), .sfd_prerr(sfd_prerr), .sfd_longerr(sfd_longerr),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 rxclk = ~rxclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  always @(posedge rxclk) ival_q <= rx_ival;

  // monitor / scoreboard
  always @(negedge rxclk) begin
    if (!rxrst) begin
      if (sfd_prerr) prerr_seen++;
      if (sfd_longerr) longerr_seen++;
      if (rx_oval) begin
        logic [EW-1:0] e;
        checks++;
        if (!ival_q) begin
          errors++;
          $display("FAIL oval_timing: oval=1 but ival at prior edge was %0b, required 1", ival_q);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: dat=%02h sop=%0b eop=%0b, required no output", rx_odat, rx_osop, rx_oeop);
        end else begin
          e = exp_q.pop_front();
          if (rx_odat !== e[EW-1 -: 8] || rx_osop !== e[LENW+2] || rx_oeop !== e[LENW+1] ||
              (e[LENW+1] && (rx_oerr !== e[LENW] || rx_olen !== e[LENW-1:0]))) begin
            errors++;
            $display("FAIL out_byte: got dat=%02h sop=%0b eop=%0b err=%0b len=%0d, required dat=%02h sop=%0b eop=%0b err=%0b len=%0d",
                     rx_odat, rx_osop, rx_oeop, rx_oerr, rx_olen,
                     e[EW-1 -: 8], e[LENW+2], e[LENW+1], e[LENW], e[LENW-1:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic ival, input logic dv, input logic [7:0] dat, input logic er);
    rx_ival = ival;
    rx_idv  = dv;
    rx_idat = dat;
    rx_ier  = er;
    @(posedge rxclk);
    #1;
  endtask

  task automatic byte_in(input logic dv, input logic [7:0] dat, input logic er, input logic gap);
    cyc(1'b1, dv, dat, er);
    if (gap) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic push_exp(input logic [7:0] d, input logic sop, input logic eop,
                          input logic err, input int len);
    exp_q.push_back({d, sop, eop, err, LENW'(len)});
  endtask

  task automatic send_frame(input int npre, input int ndata, input logic [7:0] base,
                            input int err_idx, input logic gap, input logic trail_er);
    logic ok;
    int   nout;
    ok = !upprechk || (npre >= int'(uppremin));
    if (upen) begin
      if (!ok) exp_prerr++;
      else if (ndata > 0) begin
        nout = (ndata > MAXLEN) ? MAXLEN : ndata;
        if (ndata > MAXLEN) exp_longerr++;
        for (int i = 0; i < nout; i++)
          push_exp(base + 8'(i), i == 0, i == nout - 1,
                   (ndata > MAXLEN) || (err_idx >= 0 && err_idx < nout), nout);
      end
    end
    for (int i = 0; i < npre; i++) byte_in(1'b1, 8'h55, 1'b0, gap);
    byte_in(1'b1, 8'hD5, 1'b0, gap);
    for (int i = 0; i < ndata; i++) byte_in(1'b1, base + 8'(i), i == err_idx, gap);
    byte_in(1'b0, 8'($urandom_range(0, 255)), trail_er, gap);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle(input string tag);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (prerr_seen != exp_prerr || longerr_seen != exp_longerr) begin
      errors++;
      $display("FAIL %s_pulses: prerr=%0d longerr=%0d, required prerr=%0d longerr=%0d",
               tag, prerr_seen, longerr_seen, exp_prerr, exp_longerr);
    end
  endtask

  task automatic check_quiet(input string tag);
    @(negedge rxclk);
    checks++;
    if ({rx_odat, rx_oval, rx_osop, rx_oeop, rx_oerr, rx_olen, sfd_prerr, sfd_longerr} !== '0 ||
        fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: outputs dat=%02h val=%0b sop=%0b eop=%0b err=%0b len=%0d pre=%0b long=%0b st=%0d, required all 0",
               tag, rx_odat, rx_oval, rx_osop, rx_oeop, rx_oerr, rx_olen, sfd_prerr, sfd_longerr, fsm_state);
    end
    @(posedge rxclk);
    #1;
  endtask

  // stimulus
  initial begin
    rxrst = 1'b1; rx_idat = 8'h00; rx_idv = 1'b0; rx_ier = 1'b0; rx_ival = 1'b0;
    upen = 1'b0; upprechk = 1'b0; uppremin = 3'd0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_quiet("reset_state");
    rxrst = 1'b0;
    upen  = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    send_frame(7, 64, 8'h00, -1, 1'b0, 1'b0);  settle("basic64");
    send_frame(7, 64, 8'h00, -1, 1'b1, 1'b0);  settle("gap64");
    send_frame(7, 1,  8'hA7, -1, 1'b0, 1'b0);  settle("single");
    send_frame(3, 0,  8'h00, -1, 1'b0, 1'b0);  settle("empty");
    send_frame(7, 64, 8'h40, 10, 1'b0, 1'b0);  settle("ier_mid");
    send_frame(7, 64, 8'h40, -1, 1'b0, 1'b1);  settle("ier_trail");
    send_frame(0, 5,  8'h10, -1, 1'b0, 1'b0);  settle("no_pre");

    upprechk = 1'b1; uppremin = 3'd5;
    send_frame(2, 64, 8'h20, -1, 1'b0, 1'b0);  settle("short_pre");
    send_frame(4, 8,  8'h20, -1, 1'b0, 1'b0);  settle("pre4_of5");
    send_frame(5, 8,  8'h30, -1, 1'b1, 1'b0);  settle("pre5_of5");
    send_frame(7, 64, 8'h00, -1, 1'b0, 1'b0);  settle("after_short");
    send_frame(9, 4,  8'hF0, -1, 1'b0, 1'b0);  settle("pre_sat");
    uppremin = 3'd0;
    send_frame(0, 4,  8'h60, -1, 1'b0, 1'b0);  settle("min0_direct");
    uppremin = 3'd3;
    send_frame(0, 4,  8'h60, -1, 1'b0, 1'b0);  settle("min3_direct");
    upprechk = 1'b0;

    // preamble cut by dv=0, then a junk byte outside any preamble
    exp_prerr += 2;
    repeat (3) byte_in(1'b1, 8'h55, 1'b0, 1'b0);
    byte_in(1'b0, 8'h00, 1'b0, 1'b0);
    byte_in(1'b1, 8'h12, 1'b0, 1'b0);
    byte_in(1'b1, 8'h34, 1'b0, 1'b0);
    byte_in(1'b0, 8'h00, 1'b0, 1'b0);
    settle("pre_abort");
    send_frame(7, 6,  8'h70, -1, 1'b0, 1'b0);  settle("bad_byte");

    send_frame(7, MAXLEN + 4, 8'h00, -1, 1'b0, 1'b0);  settle("trunc");
    send_frame(7, MAXLEN, 8'h00, -1, 1'b0, 1'b0);      settle("at_max");
    send_frame(7, 64, 8'h00, 20, 1'b1, 1'b0);          settle("after_trunc");

    upen = 1'b0;
    send_frame(7, 10, 8'h00, -1, 1'b0, 1'b0);  settle("disabled");
    upen = 1'b1;

    // reset in the middle of a frame: 29 bytes leave, the held one is lost
    for (int i = 0; i < 29; i++) push_exp(8'h80 + 8'(i), i == 0, 1'b0, 1'b0, 0);
    repeat (7) byte_in(1'b1, 8'h55, 1'b0, 1'b0);
    byte_in(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) byte_in(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    rxrst = 1'b1;
    check_quiet("mid_reset");
    check_quiet("mid_reset_hold");
    rxrst = 1'b0;
    settle("mid_reset_drain");
    send_frame(7, 64, 8'hC0, -1, 1'b0, 1'b0);  settle("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipsmacge_rxsfd.md
Name: ipsmacge_rxsfd

Overview:
- RX stage directly downstream of the loopback-in stage; consumes its rx_odat/rx_odv/rx_oer/rx_oval byte stream.
- Recognises preamble and SFD, strips them, and delimits each frame with sop/eop markers.
- Accumulates a per-frame error flag and byte length, and truncates oversize frames.
- Feeds the RX frame checker / FCS stage.

Parameters:
MAXLEN, 1518, maximum data bytes (DA..FCS) per frame before truncation
LENW, 14, width of length counter and rx_olen

Ports:
rxclk  in  1  RX clock; the only clock
rxrst  in  1  reset, asynchronous, active-high
rx_idat  in  8  byte from loopback-in stage
rx_idv  in  1  data valid
rx_ier  in  1  receive error
rx_ival  in  1  byte strobe; all other inputs are sampled only when 1
upen  in  1  block enable
upprechk  in  1  1 = enforce minimum preamble length
uppremin  in  3  minimum count of 0x55 bytes before SFD (0..7)
rx_odat  out  8  frame byte
rx_oval  out  1  one-cycle strobe: rx_odat and flags valid
rx_osop  out  1  first data byte of frame
rx_oeop  out  1  last data byte of frame
rx_oerr  out  1  frame error; meaningful only with rx_oeop
rx_olen  out  LENW  frame data byte count; meaningful only with rx_oeop
sfd_prerr  out  1  one-cycle pulse: bad or short preamble
sfd_longerr  out  1  one-cycle pulse: frame truncated at MAXLEN

Behaviour:
- Reset values: all outputs 0; state IDLE; holding register empty; counters 0.
- Clock gating of logic:
  - All state changes occur only on cycles with rx_ival=1.
  - rx_oval and the error pulses are registered and asserted one rxclk after the qualifying input cycle.
  - They are otherwise 0.
- State IDLE (frame idle). Transitions are evaluated only when upen=1; upen=0 holds IDLE. upen is sampled only in IDLE, so there is no mid-frame abort.
  - dv=1 and dat=0x55 -> PRE, precnt=1.
  - dv=1 and dat=0xD5:
    - with upprechk=0 or uppremin=0 -> DATA.
    - otherwise -> DROP with sfd_prerr.
  - dv=1 and any other dat -> DROP with sfd_prerr.
  - dv=0 -> stay in IDLE.
- State PRE:
  - dat=0x55 -> increment precnt, saturating at 7.
  - dat=0xD5:
    - if upprechk=0 or precnt>=uppremin -> DATA.
    - else -> DROP with sfd_prerr.
  - other byte -> DROP with sfd_prerr.
  - dv=0 -> IDLE with sfd_prerr; nothing is output.
- State DATA: one-byte holding register (hold, hvld, hsop). Output lags input by one valid byte so eop can be marked.
  - On entry: hvld=0, len=0, erracc=0.
  - dv=1:
    - if hvld, emit hold (osop=hsop, oeop=0).
    - then hold<=dat, hvld=1, len<=len+1, erracc|=ier.
    - hsop=1 only for the first byte after SFD.
  - dv=0 with hvld=1:
    - emit hold with oeop=1, oerr=erracc, olen=len.
    - -> IDLE.
    - rx_ier on the dv=0 byte is ignored.
  - dv=0 with hvld=0 (SFD followed directly by end): -> IDLE, no output, no pulse.
  - Single-byte frame: one output with osop=1 and oeop=1, olen=1.
- Truncation:
  - Applies in DATA when dv=1 arrives while len==MAXLEN and hvld=1.
  - Emit hold with oeop=1, oerr=1, olen=MAXLEN; pulse sfd_longerr.
  - -> DROP; the incoming byte is discarded.
- State DROP: discard all bytes until a valid byte with dv=0 -> IDLE.
- rx_olen never exceeds MAXLEN, so LENW must hold MAXLEN; there is no wrap.
- Reset asserted mid-frame:
  - Immediate return to IDLE; the partial frame is lost.
  - No eop is generated for it; outputs clear asynchronously.
- Gaps: rx_ival=0 cycles inside a frame are transparent. Nothing changes and no timeout applies.

Test Plan:
- 7x0x55, 0xD5, 64 data bytes 0x00..0x3F, dv drop, ival=1 every cycle -> 64 oval strobes; byte0 osop=1; byte 0x3F oeop=1, olen=64, oerr=0.
- Same frame with rx_ival toggling 1/0 -> identical output sequence; each oval follows its qualifying ival cycle by one clk.
- upprechk=1, uppremin=5, 2x0x55 then 0xD5 -> sfd_prerr pulse once, zero oval until next valid frame passes.
- rx_ier=1 on data byte 10 of a 64-byte frame -> eop with oerr=1, olen=64; ier on the trailing dv=0 byte alone -> oerr=0.
- MAXLEN=16, 20 data bytes -> 16 outputs, last has oeop=1, oerr=1, olen=16; sfd_longerr pulse; bytes 17..20 dropped; next frame normal.
- rxrst asserted after 30 data bytes, released, then normal 64-byte frame -> outputs 0 during reset, no stray eop, next frame osop/olen=64 correct.
